// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the ccff configuration-chain loader.
package ccff_pkg;

    localparam int unsigned DefaultNumChains = 10;
    localparam int unsigned DefaultChainLen  = 64;

    function automatic int unsigned count_width(input int unsigned chain_len);
        return $clog2(chain_len + 1);
    endfunction

    localparam int unsigned DefaultCntW = $clog2(DefaultChainLen + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StCheck,
        StDone,
        StErr
    } ccff_state_t;

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream-source and fabric-side signals of the ccff chain loader.
interface ccff_chain_loader_if
    import ccff_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = DefaultNumChains,
    parameter int unsigned CHAIN_LEN  = DefaultChainLen,
    localparam int unsigned CntW      = count_width(CHAIN_LEN)
);
    logic                  start;
    logic [NUM_CHAINS-1:0] cfg_word;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [NUM_CHAINS-1:0] ccff_head;
    logic                  ccff_shift;
    logic [NUM_CHAINS-1:0] ccff_tail;
    logic                  config_enable;
    logic                  CFG_DONE;
    logic                  cfg_error;
    logic [CntW-1:0]       word_count;

    // Loader side.
    modport slave (
        input  start, cfg_word, cfg_valid, ccff_tail,
        output cfg_ready, ccff_head, ccff_shift, config_enable, CFG_DONE, cfg_error, word_count
    );

    // Bitstream source / fabric side.
    modport master (
        output start, cfg_word, cfg_valid, ccff_tail,
        input  cfg_ready, ccff_head, ccff_shift, config_enable, CFG_DONE, cfg_error, word_count
    );

endinterface

// File: rtl/ccff_shift_ctrl.sv
// Word counter, registered ready, and the ccff_head/ccff_shift output registers.
module ccff_shift_ctrl
    import ccff_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = DefaultNumChains,
    parameter int unsigned CHAIN_LEN  = DefaultChainLen,
    localparam int unsigned CntW      = count_width(CHAIN_LEN)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [NUM_CHAINS-1:0] cfg_word_i,
    input  logic                  cfg_valid_i,
    output logic                  accept_o,
    output logic                  cfg_ready_o,
    output logic [NUM_CHAINS-1:0] ccff_head_o,
    output logic                  ccff_shift_o,
    output logic [CntW-1:0]       word_count_o
);

    logic [CntW-1:0]       count_q, count_d;
    logic [NUM_CHAINS-1:0] head_q, head_d;
    logic                  shift_q, shift_d;
    logic                  ready_q, ready_d;

    assign accept_o = cfg_valid_i && ready_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        shift_d = accept_o;
        if (clear_i) begin
            count_d = '0;
        end else if (accept_o && (count_q < CntW'(CHAIN_LEN))) begin
            count_d = count_q + CntW'(1);
        end
        if (accept_o) begin
            head_d = cfg_word_i;
        end
        // Ready is registered, so it looks at the post-edge state and count.
        ready_d = load_i && (count_d < CntW'(CHAIN_LEN));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            head_q  <= '0;
            shift_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
        end
    end

    assign cfg_ready_o  = ready_q;
    assign ccff_head_o  = head_q;
    assign ccff_shift_o = shift_q;
    assign word_count_o = count_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams configuration words into parallel ccff chains and verifies continuity via ccff_tail.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = DefaultNumChains,
    parameter int unsigned CHAIN_LEN  = DefaultChainLen,
    parameter bit          CHECK_TAIL = 1'b1
) (
    input logic                prog_clock,
    input logic                global_reset_n,
    ccff_chain_loader_if.slave bus
);

    localparam int unsigned CntW = count_width(CHAIN_LEN);

    ccff_state_t           state_q, state_d;
    logic                  start_take;
    logic                  accept;
    logic                  load_next;
    logic                  tail_ok;
    logic [NUM_CHAINS-1:0] first_word_q, first_word_d;

    assign start_take = bus.start && (state_q inside {StIdle, StDone, StErr});
    // After CHAIN_LEN shifts the first word sits in the last flop of every chain.
    assign tail_ok    = !CHECK_TAIL || (bus.ccff_tail == first_word_q);
    assign load_next  = (state_d == StLoad);

    ccff_shift_ctrl #(
        .NUM_CHAINS(NUM_CHAINS),
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shift_ctrl (
        .clk_i       (prog_clock),
        .rst_ni      (global_reset_n),
        .clear_i     (start_take),
        .load_i      (load_next),
        .cfg_word_i  (bus.cfg_word),
        .cfg_valid_i (bus.cfg_valid),
        .accept_o    (accept),
        .cfg_ready_o (bus.cfg_ready),
        .ccff_head_o (bus.ccff_head),
        .ccff_shift_o(bus.ccff_shift),
        .word_count_o(bus.word_count)
    );

    always_ff @(posedge prog_clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q      <= StIdle;
            first_word_q <= '0;
        end else begin
            state_q      <= state_d;
            first_word_q <= first_word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_take) state_d = StLoad;
            StLoad: begin
                if (accept && (bus.word_count == CntW'(CHAIN_LEN - 1))) state_d = StFlush;
            end
            StFlush: state_d = StCheck;
            StCheck: state_d = tail_ok ? StDone : StErr;
            StDone:  if (start_take) state_d = StLoad;
            StErr:   if (start_take) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        first_word_d = first_word_q;
        if (accept && (bus.word_count == '0)) first_word_d = bus.cfg_word;
    end

    always_comb begin
        bus.config_enable = state_q inside {StLoad, StFlush, StCheck, StDone};
        bus.CFG_DONE      = (state_q == StDone);
        bus.cfg_error     = (state_q == StErr);
    end

endmodule
